// File: rtl/enemy_pkg.sv
// enemy_pkg: state encoding, formation geometry and index widths shared by the formation controller
package enemy_pkg;
  typedef enum logic [2:0] {IDLE, MARCH, DESCEND, CLEARED, LANDED} state_t;
  localparam int ROWS = 4;
  localparam int COLS = 8;
  localparam int COL_PITCH = 60;
  localparam int ROW_PITCH = 50;
  localparam int SPRITE_W = 50;
  localparam int SPRITE_H = 50;
  localparam int START_X = 40;
  localparam int START_Y = 40;
  localparam int STEP_X = 4;
  localparam int STEP_Y = 16;
  localparam int LEFT_BOUND = 0;
  localparam int RIGHT_BOUND = 639;
  localparam int BOTTOM_BOUND = 400;
  localparam int BASE_PERIOD = 32;
  localparam int MIN_PERIOD = 2;
  localparam int ROW_W = 3;
  localparam int COL_W = 4;
  localparam int IDX_W = $clog2(ROWS * COLS);
  localparam int POP_W = 6;
  localparam int PER_W = 7;
  localparam int COORD_W = 10;
  localparam int EDGE_W = 11;
endpackage

// File: rtl/enemy_mask_extents.sv
// enemy_mask_extents: live-column/row extents and population count of the alive mask
module enemy_mask_extents
  import enemy_pkg::*;
(
  input  logic [ROWS*COLS-1:0] alive_mask,
  output logic [COL_W-1:0]     lcol,
  output logic [COL_W-1:0]     rcol,
  output logic [ROW_W-1:0]     brow,
  output logic [POP_W-1:0]     alive_count,
  output logic                 any_alive
);
  logic [COLS-1:0] col_any;
  logic [ROWS-1:0] row_any;
  always_comb begin
    col_any = '0;
    row_any = '0;
    alive_count = '0;
    for (int i = 0; i < ROWS * COLS; i++) begin
      col_any[i % COLS] = col_any[i % COLS] | alive_mask[i];
      row_any[i / COLS] = row_any[i / COLS] | alive_mask[i];
      alive_count = alive_count + POP_W'(alive_mask[i]);
    end
    lcol = '0;
    rcol = '0;
    brow = '0;
    for (int c = COLS - 1; c >= 0; c--) if (col_any[c]) lcol = COL_W'(c);
    for (int c = 0; c < COLS; c++) if (col_any[c]) rcol = COL_W'(c);
    for (int r = 0; r < ROWS; r++) if (row_any[r]) brow = ROW_W'(r);
  end
  assign any_alive = |alive_mask;
endmodule

// File: rtl/enemy_formation_ctrl.sv
// enemy_formation_ctrl: marches the alien formation, handles kills, descends and end-of-wave flags
module enemy_formation_ctrl
  import enemy_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 start,
  input  logic                 frame_tick,
  input  logic                 kill_valid,
  input  logic [2:0]           kill_row,
  input  logic [3:0]           kill_col,
  output logic [9:0]           formation_x,
  output logic [9:0]           formation_y,
  output logic                 enemy_direction_X,
  output logic                 enemy_direction_Y,
  output logic                 step_pulse,
  output logic [ROWS*COLS-1:0] alive_mask,
  output logic [5:0]           alive_count,
  output logic                 all_dead,
  output logic                 landed
);
  state_t state, state_d;
  logic [COORD_W-1:0] fx_d, fy_d;
  logic dir_d, step_d, kill_hit, hit_wall, any_alive;
  logic [ROWS*COLS-1:0] mask_d;
  logic [PER_W-1:0] cnt, cnt_d, period;
  logic [COL_W-1:0] lcol, rcol;
  logic [ROW_W-1:0] brow;
  logic [IDX_W-1:0] kill_idx;
  logic [EDGE_W-1:0] left_edge, right_edge, bottom_next;
  enemy_mask_extents u_ext (
    .alive_mask(alive_mask),
    .lcol(lcol),
    .rcol(rcol),
    .brow(brow),
    .alive_count(alive_count),
    .any_alive(any_alive)
  );
  assign kill_idx = IDX_W'(int'(kill_row) * COLS + int'(kill_col));
  assign kill_hit = kill_valid && (state == MARCH || state == DESCEND) && int'(kill_row) < ROWS
                    && int'(kill_col) < COLS && alive_mask[kill_idx];
  // Fewer survivors march faster, floored at the minimum cadence
  assign period = (PER_W'(alive_count) + PER_W'(BASE_PERIOD) < PER_W'(ROWS * COLS + MIN_PERIOD))
                  ? PER_W'(MIN_PERIOD) : PER_W'(alive_count) + PER_W'(BASE_PERIOD) - PER_W'(ROWS * COLS);
  assign left_edge = EDGE_W'(formation_x) + EDGE_W'(lcol) * EDGE_W'(COL_PITCH);
  assign right_edge = EDGE_W'(formation_x) + EDGE_W'(rcol) * EDGE_W'(COL_PITCH) + EDGE_W'(SPRITE_W - 1);
  assign bottom_next = EDGE_W'(formation_y) + EDGE_W'(STEP_Y) + EDGE_W'(brow) * EDGE_W'(ROW_PITCH)
                       + EDGE_W'(SPRITE_H - 1);
  assign hit_wall = enemy_direction_X ? right_edge + EDGE_W'(STEP_X) > EDGE_W'(RIGHT_BOUND)
                                      : left_edge < EDGE_W'(LEFT_BOUND + STEP_X);
  assign enemy_direction_Y = state == DESCEND;
  assign all_dead = state == CLEARED;
  assign landed = state == LANDED;
  always_comb begin
    state_d = state;
    fx_d = formation_x;
    fy_d = formation_y;
    dir_d = enemy_direction_X;
    mask_d = alive_mask;
    cnt_d = cnt;
    step_d = 1'b0;
    if (kill_hit) mask_d[kill_idx] = 1'b0;
    if (start) begin
      state_d = MARCH;
      fx_d = COORD_W'(START_X);
      fy_d = COORD_W'(START_Y);
      dir_d = 1'b1;
      mask_d = '1;
      cnt_d = '0;
    end else if (kill_hit && alive_count == POP_W'(1))
      state_d = CLEARED;
    else if (state == DESCEND) begin
      fy_d = formation_y + COORD_W'(STEP_Y);
      dir_d = ~enemy_direction_X;
      state_d = bottom_next >= EDGE_W'(BOTTOM_BOUND) ? LANDED : MARCH;
    end else if (state == MARCH && frame_tick && any_alive) begin
      if (cnt + PER_W'(1) < period) cnt_d = cnt + PER_W'(1);
      else begin
        cnt_d = '0;
        state_d = hit_wall ? DESCEND : MARCH;
        fx_d = hit_wall ? formation_x
             : enemy_direction_X ? formation_x + COORD_W'(STEP_X) : formation_x - COORD_W'(STEP_X);
        step_d = ~hit_wall;
      end
    end
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state <= IDLE;
      formation_x <= COORD_W'(START_X);
      formation_y <= COORD_W'(START_Y);
      enemy_direction_X <= 1'b1;
      alive_mask <= '0;
      cnt <= '0;
      step_pulse <= 1'b0;
    end else begin
      state <= state_d;
      formation_x <= fx_d;
      formation_y <= fy_d;
      enemy_direction_X <= dir_d;
      alive_mask <= mask_d;
      cnt <= cnt_d;
      step_pulse <= step_d;
    end
endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// tb_enemy_formation_ctrl: directed vectors, corner sequences and random traffic against a behavioural formation model
module tb_enemy_formation_ctrl;
  logic Clk = 1'b0, Reset_n = 1'b0, start = 1'b0, frame_tick = 1'b0, kill_valid = 1'b0;
  logic [2:0] kill_row = '0;
  logic [3:0] kill_col = '0;
  logic [9:0] formation_x, formation_y;
  logic enemy_direction_X, enemy_direction_Y, step_pulse, all_dead, landed;
  logic [31:0] alive_mask;
  logic [5:0] alive_count;
  int n_chk = 0, n_pass = 0;
  localparam int P_IDLE = 0, P_MARCH = 1, P_DESCEND = 2, P_CLEARED = 3, P_LANDED = 4;
  int m_phase, m_x, m_y, m_cnt;
  bit m_right, m_step;
  bit m_alive [4][8];
  typedef struct {bit st; bit kv; int kr; int kc; int cnt;} kvec_t;
  kvec_t tbl [8];

  enemy_formation_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .frame_tick(frame_tick),
    .kill_valid(kill_valid), .kill_row(kill_row), .kill_col(kill_col),
    .formation_x(formation_x), .formation_y(formation_y),
    .enemy_direction_X(enemy_direction_X), .enemy_direction_Y(enemy_direction_Y),
    .step_pulse(step_pulse), .alive_mask(alive_mask), .alive_count(alive_count),
    .all_dead(all_dead), .landed(landed)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int m_count();
    int n = 0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) n += int'(m_alive[r][c]);
    return n;
  endfunction

  task automatic m_reset();
    m_phase = P_IDLE; m_x = 40; m_y = 40; m_right = 1; m_step = 0; m_cnt = 0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) m_alive[r][c] = 0;
  endtask

  // One clock of the game rules, evaluated on the pre-edge alive set
  task automatic m_apply(input bit st, input bit tk, input bit kv, input int kr, input int kc);
    int n, lc, rc, br, per;
    bit hit, wall;
    n = 0; lc = 7; rc = 0; br = 0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 8; c++)
        if (m_alive[r][c]) begin
          n++;
          if (c < lc) lc = c;
          if (c > rc) rc = c;
          if (r > br) br = r;
        end
    per = 32 - (32 - n);
    if (per < 2) per = 2;
    hit = kv && (m_phase == P_MARCH || m_phase == P_DESCEND) && kr < 4 && kc < 8 && m_alive[kr][kc];
    m_step = 0;
    if (st) begin
      for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) m_alive[r][c] = 1;
      m_phase = P_MARCH; m_x = 40; m_y = 40; m_right = 1; m_cnt = 0;
    end else begin
      if (hit) m_alive[kr][kc] = 0;
      if (hit && n == 1) m_phase = P_CLEARED;
      else if (m_phase == P_DESCEND) begin
        m_y += 16;
        m_right = !m_right;
        m_phase = (m_y + br * 50 + 49 >= 400) ? P_LANDED : P_MARCH;
      end else if (m_phase == P_MARCH && tk) begin
        if (m_cnt + 1 < per) m_cnt++;
        else begin
          m_cnt = 0;
          wall = m_right ? (m_x + rc * 60 + 49 + 4 > 639) : (m_x + lc * 60 < 4);
          if (wall) m_phase = P_DESCEND;
          else begin
            m_x = (m_x + (m_right ? 4 : -4)) & 1023;
            m_step = 1;
          end
        end
      end
    end
  endtask

  task automatic cmp_model();
    logic [63:0] aa, ea, em;
    em = '0;
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) em[r*8+c] = m_alive[r][c];
    aa = {33'b0, formation_x, formation_y, enemy_direction_X, enemy_direction_Y, step_pulse, alive_count, all_dead, landed};
    ea = {33'b0, 10'(m_x), 10'(m_y), m_right, m_phase == P_DESCEND, m_step, 6'(m_count()),
          m_phase == P_CLEARED, m_phase == P_LANDED};
    chk("model_outputs", aa, ea);
    chk("model_mask", {32'b0, alive_mask}, em);
  endtask

  task automatic cyc(input bit st, input bit tk, input bit kv, input int kr, input int kc);
    start = st; frame_tick = tk; kill_valid = kv; kill_row = 3'(kr); kill_col = 4'(kc);
    @(posedge Clk);
    m_apply(st, tk, kv, kr, kc);
    @(negedge Clk);
    start = 0; frame_tick = 0; kill_valid = 0;
    cmp_model();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, formation_x, 40);
    chk({tag, "_y"}, formation_y, 40);
    chk({tag, "_dirx"}, enemy_direction_X, 1);
    chk({tag, "_diry"}, enemy_direction_Y, 0);
    chk({tag, "_step"}, step_pulse, 0);
    chk({tag, "_mask"}, alive_mask, 0);
    chk({tag, "_count"}, alive_count, 0);
    chk({tag, "_dead"}, all_dead, 0);
    chk({tag, "_landed"}, landed, 0);
  endtask

  initial begin
    bit seen;
    tbl[0] = '{1, 0, 0, 0, 32};
    tbl[1] = '{0, 1, 0, 3, 31};
    tbl[2] = '{0, 1, 0, 3, 31};
    tbl[3] = '{0, 1, 5, 9, 31};
    tbl[4] = '{0, 1, 3, 7, 30};
    tbl[5] = '{0, 1, 4, 0, 30};
    tbl[6] = '{0, 1, 0, 8, 30};
    tbl[7] = '{0, 1, 1, 1, 29};
    m_reset();
    repeat (3) @(negedge Clk);
    chk_reset("reset");
    Reset_n = 1;
    @(negedge Clk);
    cmp_model();
    // First step lands on the 32nd tick with a full formation
    cyc(1, 0, 0, 0, 0);
    chk("start_x", formation_x, 40);
    chk("start_count", alive_count, 32);
    seen = 0;
    for (int i = 0; i < 31; i++) begin cyc(0, 1, 0, 0, 0); seen |= step_pulse; end
    chk("no_early_step", seen, 0);
    chk("x_before_step", formation_x, 40);
    cyc(0, 1, 0, 0, 0);
    chk("first_step", step_pulse, 1);
    chk("x_after_step", formation_x, 44);
    for (int i = 0; i < 2000 && !enemy_direction_Y; i++) cyc(0, 1, 0, 0, 0);
    chk("descend_reached", enemy_direction_Y, 1);
    chk("descend_x", formation_x, 168);
    chk("pre_descend_y", formation_y, 40);
    cyc(0, 1, 0, 0, 0);
    chk("descend_y", formation_y, 56);
    chk("descend_dir", enemy_direction_X, 0);
    chk("descend_pulse_once", enemy_direction_Y, 0);
    chk("descend_x_hold", formation_x, 168);
    // Column 7 gone: faster cadence and a later right-hand reversal
    cyc(1, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) cyc(0, 0, 1, r, 7);
    chk("col7_count", alive_count, 28);
    seen = 0;
    for (int i = 0; i < 27; i++) begin cyc(0, 1, 0, 0, 0); seen |= step_pulse; end
    chk("col7_no_early_step", seen, 0);
    cyc(0, 1, 0, 0, 0);
    chk("col7_step", step_pulse, 1);
    chk("col7_x_step", formation_x, 44);
    for (int i = 0; i < 3000 && !enemy_direction_Y; i++) cyc(0, 1, 0, 0, 0);
    chk("col7_descend", enemy_direction_Y, 1);
    chk("col7_descend_x", formation_x, 228);
    for (int i = 0; i < 8; i++) begin
      cyc(tbl[i].st, 0, tbl[i].kv, tbl[i].kr, tbl[i].kc);
      chk($sformatf("kill_vec%0d", i), alive_count, tbl[i].cnt);
    end
    chk("bit_0_3_dead", alive_mask[3], 0);
    // Final kill coincides with a step-boundary tick
    cyc(1, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) if (!(r == 2 && c == 5)) cyc(0, 0, 1, r, c);
    chk("last_one_count", alive_count, 1);
    cyc(0, 1, 0, 0, 0);
    chk("last_one_no_step", step_pulse, 0);
    cyc(0, 1, 1, 2, 5);
    chk("cleared_dead", all_dead, 1);
    chk("cleared_step", step_pulse, 0);
    chk("cleared_x", formation_x, 40);
    chk("cleared_mask", alive_mask, 0);
    repeat (5) cyc(0, 1, 1, 2, 5);
    chk("cleared_hold", all_dead, 1);
    // Two survivors on the bottom row descend at minimum cadence until landing
    cyc(1, 0, 0, 0, 0);
    for (int r = 0; r < 4; r++) for (int c = 0; c < 8; c++) if (!(r == 3 && (c == 0 || c == 7))) cyc(0, 0, 1, r, c);
    chk("land_count", alive_count, 2);
    for (int i = 0; i < 8000 && !landed; i++) cyc(0, 1, 0, 0, 0);
    chk("landed", landed, 1);
    chk("landed_y", formation_y, 216);
    chk("landed_x", formation_x, 168);
    seen = 0;
    for (int i = 0; i < 20; i++) begin cyc(0, 1, 0, 0, 0); seen |= step_pulse; end
    chk("landed_no_step", seen, 0);
    chk("landed_y_hold", formation_y, 216);
    chk("landed_hold", landed, 1);
    // Asynchronous reset in the middle of a march
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 70; i++) cyc(0, 1, 0, 0, 0);
    chk("pre_reset_x", formation_x, 48);
    #2 Reset_n = 0;
    #1 chk_reset("async_reset");
    m_reset();
    @(negedge Clk);
    Reset_n = 1;
    cmp_model();
    cyc(1, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) != 0, $urandom_range(0, 4) == 0,
          int'($urandom_range(0, 4)), int'($urandom_range(0, 9)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/enemy_formation_ctrl.md
Name: enemy_formation_ctrl

Overview:
Sequences the alien formation. Owns the formation origin, the march direction, the alive mask and the march cadence. On each frame tick it decides whether to step sideways, descend and reverse, or stop. It drives the enemy_direction_X/enemy_direction_Y and start-position inputs of every per-alien enemy sprite instance. Collision logic reports kills to it, and the top-level game FSM reads its all_dead and landed flags.

Parameters:
ROWS, 4, formation rows
COLS, 8, formation columns
COL_PITCH, 60, pixel distance between column origins
ROW_PITCH, 50, pixel distance between row origins
SPRITE_W, 50, alien sprite width in pixels
SPRITE_H, 50, alien sprite height in pixels
START_X, 40, origin x after start
START_Y, 40, origin y after start
STEP_X, 4, horizontal pixels per march step
STEP_Y, 16, vertical pixels per descend
LEFT_BOUND, 0, leftmost legal pixel
RIGHT_BOUND, 639, rightmost legal pixel
BOTTOM_BOUND, 400, landed when any live alien's bottom pixel is at or beyond this
BASE_PERIOD, 32, frames per step with the full formation alive
MIN_PERIOD, 2, minimum frames per step

Ports:
Clk  in  1  system clock
Reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; (re)starts the formation
frame_tick  in  1  one-cycle pulse per video frame, synchronous to Clk
kill_valid  in  1  collision reports a hit this cycle
kill_row  in  3  row of the hit alien
kill_col  in  4  column of the hit alien
formation_x  out  10  origin x of alien (0,0)
formation_y  out  10  origin y of alien (0,0)
enemy_direction_X  out  1  0 = left, 1 = right
enemy_direction_Y  out  1  one-cycle pulse on descend
step_pulse  out  1  one-cycle pulse on each sideways step
alive_mask  out  ROWS*COLS  bit r*COLS+c set = alien alive
alive_count  out  6  popcount of alive_mask
all_dead  out  1  high in CLEARED
landed  out  1  high in LANDED

Behaviour:
- Reset (async, Reset_n=0). Resulting values:
  - state IDLE
  - formation_x=START_X, formation_y=START_Y
  - enemy_direction_X=1
  - alive_mask=0, alive_count=0
  - all pulses and flags 0
  - frame counter 0
- States: IDLE, MARCH, DESCEND, CLEARED, LANDED.
- start (accepted in any state; highest priority after reset):
  - mask all ones, origin reset, direction right, counter 0
  - next state MARCH
- Derived values, combinational from the registered mask:
  - lcol/rcol = lowest/highest column with any live alien
  - brow = highest row with any live alien
  - left_edge = formation_x + lcol*COL_PITCH
  - right_edge = formation_x + rcol*COL_PITCH + SPRITE_W - 1
  - bottom_edge = formation_y + brow*ROW_PITCH + SPRITE_H - 1
  - All arithmetic is 11-bit to avoid overflow.
- period = max(MIN_PERIOD, BASE_PERIOD - (ROWS*COLS - alive_count)).
- MARCH, on frame_tick:
  - If counter+1 < period: counter increments; nothing else happens.
  - Otherwise counter clears, then:
    - Right and right_edge+STEP_X > RIGHT_BOUND, or left and left_edge < LEFT_BOUND+STEP_X: go to DESCEND; x unchanged.
    - Else: formation_x += or -= STEP_X and step_pulse=1 for one cycle.
- DESCEND lasts exactly one cycle:
  - formation_y += STEP_Y
  - enemy_direction_X toggles
  - enemy_direction_Y=1 that cycle
  - next state LANDED if the new bottom_edge >= BOTTOM_BOUND, else MARCH.
- Kill (any state except IDLE):
  - Clears the addressed bit at the end of the cycle.
  - Out-of-range indices or already-dead aliens are ignored.
  - alive_count updates the next cycle.
- Same-cycle kill and frame_tick: the step decision uses the pre-kill mask.
- A kill that empties the mask goes to CLEARED, taking priority over DESCEND/LANDED in that cycle.
- CLEARED and LANDED hold all outputs until start or reset. Kills are still masked, with no effect.
- frame_tick is ignored in IDLE, CLEARED and LANDED.

Decomposition:
- Package enemy_pkg holds:
  - the state enum
  - the geometry constants (pitch, sprite size, bounds)
  - the index widths
- Sub-module enemy_mask_extents (purely combinational) takes alive_mask and produces lcol, rcol, brow, alive_count and an any_alive flag.

Test Plan:
- Reset, then start, then 31 frame_ticks: no step_pulse; formation_x=40. 32nd tick: step_pulse, formation_x=44.
- March right with a full mask: after 32 steps formation_x=168 (right_edge 637). The next period gives DESCEND: formation_y=56, enemy_direction_X=0, enemy_direction_Y pulses, and x stays at 168.
- Kill all of column 7: rcol=6. The reversal then needs origin_x such that right_edge+4>639, i.e. formation_x reaches 228 before DESCEND. alive_count=28, period=28.
- Kill (0,3) twice, then out-of-range (5,9): alive_count 32→31 once; the second and third kills cause no change.
- Kill all 32 aliens, with the last kill coinciding with a frame_tick at the step boundary: all_dead=1, state CLEARED, no step_pulse.
- Repeated descends until bottom_edge>=400: landed=1 and frame_ticks are ignored. Then Reset_n low mid-march: outputs return to reset values immediately, asynchronously.
